parking_gate_arbiter: RTL and testbench
=======================================

# parking_gate_arbiter

Shares the single barrier gate of the car park between an entry lane and an exit lane. It arbitrates simultaneous requests round-robin, sequences the gate through open, pass and close phases, and keeps the authoritative occupancy count. It sits between the lane sensors / password front-end and the gate motor driver.

## Interface
- CAPACITY, 8: number of parking spaces; occupancy never exceeds it.
- CNT_W, 4: occupancy width; must satisfy 2^CNT_W > CAPACITY.
- OPEN_CYCLES, 4: gate travel time in cycles, for both opening and closing.
- PASS_CYCLES, 16: cycles allowed for a car to pass before timeout.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- entry_req  input  1  level request from the entry lane (password already validated upstream).
- exit_req  input  1  level request from the exit lane.
- car_passed  input  1  one-cycle pulse from the under-gate loop sensor.
- entry_grant  output  1  entry lane owns the gate.
- exit_grant  output  1  exit lane owns the gate.
- gate_open  output  1  gate motor command: 1 = open, 0 = close.
- occupancy  output  CNT_W  number of parked cars.
- full  output  1  occupancy == CAPACITY.
- empty  output  1  occupancy == 0.
- busy  output  1  FSM is not in IDLE.
- timeout_err  output  1  one-cycle pulse when the pass window expires.

## Operation
- Reset values:
  - all outputs 0 except empty = 1;
  - occupancy = 0;
  - FSM = IDLE;
  - last_served = EXIT, so entry wins the first tie.
- Eligibility:
  - entry is eligible when entry_req = 1 and full = 0;
  - exit is eligible when exit_req = 1 and empty = 0;
  - an ineligible request is never granted and is not latched.
- FSM states: IDLE, OPENING, PASS, CLOSING.
- IDLE:
  - one eligible requester: grant it;
  - both eligible: grant the lane other than last_served;
  - on a grant, set last_served to the granted lane and go to OPENING.
- OPENING: gate_open = 1. Count OPEN_CYCLES cycles, then go to PASS.
- PASS: gate_open = 1.
  - car_passed = 1: occupancy +1 for an entry grant, −1 for an exit grant; go to CLOSING.
  - Otherwise, after PASS_CYCLES cycles: pulse timeout_err, leave occupancy unchanged, go to CLOSING.
- CLOSING: gate_open = 0, grants cleared. Count OPEN_CYCLES cycles, then go to IDLE.
- Exactly one grant is high during OPENING and PASS. Both grants are 0 in IDLE and CLOSING.
- The requester's lane is held for the whole transaction. A request that drops mid-transaction is ignored; the transaction completes, normally by timeout.
- car_passed outside PASS is ignored.
- Arithmetic: occupancy cannot wrap, because a transaction is never granted when full (entry) or empty (exit).

## Timing
- Request high at rising edge t while in IDLE: grant, gate_open and busy are high from t, and the FSM is in OPENING.
- OPENING occupies exactly OPEN_CYCLES cycles. PASS is entered on edge t+OPEN_CYCLES.
- car_passed sampled high at edge p:
  - occupancy, full and empty update at p;
  - grants and gate_open drop at p (CLOSING entered).
- Timeout:
  - the PASS counter starts at 0 on PASS entry;
  - when it reaches PASS_CYCLES−1 without car_passed, timeout_err is high for the following cycle;
  - CLOSING is entered on the same edge.
- car_passed on the final PASS cycle is a pass, not a timeout.
- CLOSING lasts OPEN_CYCLES cycles, then IDLE for at least one cycle. The next grant is no earlier than the edge after IDLE entry.
- Reset mid-operation:
  - immediate return to reset values, gate commanded closed;
  - the pending occupancy change is lost.

## Configuration
- PARKING_TIMEOUT_EN
  - Defined: the PASS timeout behaves as above.
  - Undefined: PASS waits indefinitely for car_passed, timeout_err is tied 0, and no pass counter is synthesised.

## Test plan
Defaults: CAPACITY=8, OPEN_CYCLES=4, PASS_CYCLES=16.
- Single entry: entry_req=1, car_passed pulse 3 cycles into PASS → entry_grant high 7 cycles, occupancy 0→1, busy low 4 cycles after the pass.
- Tie: entry_req and exit_req both held with occupancy=3 → grants alternate entry, exit, entry; occupancy ends at 4.
- Full: 8 entries → full=1. A further entry_req is never granted. exit_req is granted; after its pass occupancy=7 and full=0.
- Empty: exit_req at reset → no grant, busy stays 0.
- Timeout (macro defined): entry grant with no car_passed → timeout_err pulses once, 4+16 cycles after grant; occupancy unchanged; gate_open falls on the same edge.
- Reset: rst low during PASS → all grants 0 and gate_open 0 immediately; occupancy=0; the next entry is served normally.

Source files
------------

// File: rtl/parking_gate_if.sv
// Lane-side handshake and status bundle between the lane front-end and the gate arbiter.
interface parking_gate_if #(
    parameter int unsigned CNT_W = 4
);
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             entry_grant;
    logic             exit_grant;
    logic             gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             busy;
    logic             timeout_err;

    modport master (
        output entry_req, exit_req, car_passed,
        input  entry_grant, exit_grant, gate_open, occupancy, full, empty, busy, timeout_err
    );

    modport slave (
        input  entry_req, exit_req, car_passed,
        output entry_grant, exit_grant, gate_open, occupancy, full, empty, busy, timeout_err
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin owner of the car-park barrier: sequences open/pass/close and keeps occupancy.
// Optional macro PARKING_TIMEOUT_EN enables the PASS-window timeout and timeout_err pulse.
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned OPEN_CYCLES = 4,
    parameter int unsigned PASS_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    parking_gate_if.slave bus
);

`ifdef PARKING_TIMEOUT_EN
    localparam int unsigned TMR_MAX = (PASS_CYCLES > OPEN_CYCLES) ? PASS_CYCLES : OPEN_CYCLES;
`else
    localparam int unsigned TMR_MAX = OPEN_CYCLES;
`endif
    localparam int unsigned TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    if (((64'd1 << CNT_W) <= 64'(CAPACITY)) || (OPEN_CYCLES == 0) || (PASS_CYCLES == 0)) begin : g_bad_params
        $error("parking_gate_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_OPENING, S_PASS, S_CLOSING} state_e;
    typedef enum logic {LANE_ENTRY, LANE_EXIT} lane_e;

    state_e           state;
    lane_e            last_served;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] occ_q;
    logic             entry_grant_q;
    logic             exit_grant_q;
    logic             gate_open_q;
    logic             busy_q;
    logic             full_q;
    logic             empty_q;

    logic             entry_ok_c;
    logic             exit_ok_c;
    logic             pick_entry_c;
    logic [CNT_W-1:0] occ_next_c;

    // Eligibility and round-robin pick; the owner lane decides the occupancy step.
    always_comb begin
        entry_ok_c   = bus.entry_req && !full_q;
        exit_ok_c    = bus.exit_req && !empty_q;
        pick_entry_c = entry_ok_c && (!exit_ok_c || (last_served == LANE_EXIT));
        occ_next_c   = entry_grant_q ? (occ_q + CNT_W'(1)) : (occ_q - CNT_W'(1));
    end

`ifdef PARKING_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == S_PASS) && !bus.car_passed
                         && (tmr == TMR_W'(PASS_CYCLES - 1));
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            last_served   <= LANE_EXIT;
            tmr           <= '0;
            occ_q         <= '0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            gate_open_q   <= 1'b0;
            busy_q        <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (entry_ok_c || exit_ok_c) begin
                        state         <= S_OPENING;
                        tmr           <= '0;
                        gate_open_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        entry_grant_q <= pick_entry_c;
                        exit_grant_q  <= !pick_entry_c;
                        last_served   <= pick_entry_c ? LANE_ENTRY : LANE_EXIT;
                    end
                end
                S_OPENING: begin
                    if (tmr == TMR_W'(OPEN_CYCLES - 1)) begin
                        state <= S_PASS;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_PASS: begin
                    if (bus.car_passed) begin
                        occ_q         <= occ_next_c;
                        full_q        <= (occ_next_c == CNT_W'(CAPACITY));
                        empty_q       <= (occ_next_c == '0);
                        state         <= S_CLOSING;
                        tmr           <= '0;
                        gate_open_q   <= 1'b0;
                        entry_grant_q <= 1'b0;
                        exit_grant_q  <= 1'b0;
                    end
`ifdef PARKING_TIMEOUT_EN
                    else if (tmr == TMR_W'(PASS_CYCLES - 1)) begin
                        state         <= S_CLOSING;
                        tmr           <= '0;
                        gate_open_q   <= 1'b0;
                        entry_grant_q <= 1'b0;
                        exit_grant_q  <= 1'b0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
`endif
                end
                S_CLOSING: begin
                    if (tmr == TMR_W'(OPEN_CYCLES - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.entry_grant = entry_grant_q;
    assign bus.exit_grant  = exit_grant_q;
    assign bus.gate_open   = gate_open_q;
    assign bus.busy        = busy_q;
    assign bus.occupancy   = occ_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed table, corner sequences, random vs model.
module tb_parking_gate_arbiter;

    localparam int unsigned CAPACITY    = 8;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned OPEN_CYCLES = 4;
    localparam int unsigned PASS_CYCLES = 16;
`ifdef PARKING_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    parking_gate_if #(.CNT_W(CNT_W)) bus ();

    parking_gate_arbiter #(
        .CAPACITY   (CAPACITY),
        .CNT_W      (CNT_W),
        .OPEN_CYCLES(OPEN_CYCLES),
        .PASS_CYCLES(PASS_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: owner lane, edges since grant, edges since close began.
    int m_owner;   // 0 none, 1 entry, 2 exit
    int m_g;
    int m_c;       // -1 while gate not closing
    int m_occ;
    int m_last;
    bit m_to;

    function automatic void model_reset();
        m_owner = 0; m_g = 0; m_c = -1; m_occ = 0; m_last = 2; m_to = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit x, bit cp);
        bit e_ok;
        bit x_ok;
        m_to = 1'b0;
        if (m_owner == 0) begin
            e_ok = e && (m_occ < int'(CAPACITY));
            x_ok = x && (m_occ > 0);
            if (e_ok && (!x_ok || m_last == 2)) m_owner = 1;
            else if (x_ok)                      m_owner = 2;
            if (m_owner != 0) begin
                m_last = m_owner; m_g = 0; m_c = -1;
            end
        end else if (m_c >= 0) begin
            m_c++;
            if (m_c == int'(OPEN_CYCLES)) m_owner = 0;
        end else if (m_g < int'(OPEN_CYCLES)) begin
            m_g++;
        end else if (cp) begin
            m_occ += (m_owner == 1) ? 1 : -1;
            m_c = 0;
        end else if (TIMEOUT_EN && (m_g - int'(OPEN_CYCLES) == int'(PASS_CYCLES) - 1)) begin
            m_to = 1'b1;
            m_c  = 0;
        end else begin
            m_g++;
        end
    endfunction

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic compare_all();
        check("entry_grant", int'(bus.entry_grant), int'(m_owner == 1 && m_c < 0));
        check("exit_grant",  int'(bus.exit_grant),  int'(m_owner == 2 && m_c < 0));
        check("gate_open",   int'(bus.gate_open),   int'(m_owner != 0 && m_c < 0));
        check("busy",        int'(bus.busy),        int'(m_owner != 0));
        check("occupancy",   int'(bus.occupancy),   m_occ);
        check("full",        int'(bus.full),        int'(m_occ == int'(CAPACITY)));
        check("empty",       int'(bus.empty),       int'(m_occ == 0));
        check("timeout_err", int'(bus.timeout_err), int'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(bus.entry_req, bus.exit_req, bus.car_passed);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_gate_closed", int'(bus.gate_open), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One transaction; exp_lane 0 means no grant may appear.
    task automatic run_txn(input bit e, input bit x, input int exp_lane, input bit pass);
        int lane;
        int n;
        bus.entry_req = e;
        bus.exit_req  = x;
        lane = 0;
        for (int i = 0; i < 6 && lane == 0; i++) begin
            tick();
            if (bus.entry_grant)     lane = 1;
            else if (bus.exit_grant) lane = 2;
        end
        check("grant_lane", lane, exp_lane);
        if (lane != 0) begin
            if (pass) begin
                repeat (OPEN_CYCLES) tick();
                bus.car_passed = 1'b1;
                tick();
                bus.car_passed = 1'b0;
                check("gate_after_pass", int'(bus.gate_open), 0);
            end else begin
                n = 0;
                while (!bus.timeout_err && n < int'(OPEN_CYCLES + PASS_CYCLES) + 8) begin
                    tick();
                    n++;
                end
                check("timeout_latency", n, int'(OPEN_CYCLES + PASS_CYCLES));
                check("gate_at_timeout", int'(bus.gate_open), 0);
            end
            n = 0;
            while (bus.busy && n < 2 * int'(OPEN_CYCLES) + 4) begin
                tick();
                n++;
            end
            check("idle_reached", int'(bus.busy), 0);
        end else begin
            check("no_grant_busy", int'(bus.busy), 0);
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
    endtask

    typedef struct {
        bit e, x, cp;
        bit eg, xg, go, busy;
        int occ;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int occ_before;
        vectors     = 0;
        miscompares = 0;

        // Single entry from reset: pass 3 cycles into PASS, request dropped after the grant.
        tbl[0]  = '{1, 0, 0, 1, 0, 1, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[5]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1};

        rst            = 1'b0;
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.car_passed = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_empty", int'(bus.empty), 1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.entry_req  = tbl[i].e;
            bus.exit_req   = tbl[i].x;
            bus.car_passed = tbl[i].cp;
            tick();
            check($sformatf("tbl%0d_entry_grant", i), int'(bus.entry_grant), int'(tbl[i].eg));
            check($sformatf("tbl%0d_exit_grant", i),  int'(bus.exit_grant),  int'(tbl[i].xg));
            check($sformatf("tbl%0d_gate_open", i),   int'(bus.gate_open),   int'(tbl[i].go));
            check($sformatf("tbl%0d_busy", i),        int'(bus.busy),        int'(tbl[i].busy));
            check($sformatf("tbl%0d_occupancy", i),   int'(bus.occupancy),   tbl[i].occ);
        end
        bus.car_passed = 1'b0;

        // Build occupancy 3 with the exit lane served last, then a held tie.
        run_txn(1'b1, 1'b0, 1, 1'b1);
        run_txn(1'b1, 1'b0, 1, 1'b1);
        run_txn(1'b1, 1'b0, 1, 1'b1);
        run_txn(1'b0, 1'b1, 2, 1'b1);
        check("occ_before_tie", int'(bus.occupancy), 3);
        run_txn(1'b1, 1'b1, 1, 1'b1);
        run_txn(1'b1, 1'b1, 2, 1'b1);
        run_txn(1'b1, 1'b1, 1, 1'b1);
        check("occ_after_tie", int'(bus.occupancy), 4);

        // Fill up, refuse entry while full, then let one car out.
        repeat (4) run_txn(1'b1, 1'b0, 1, 1'b1);
        check("full_set", int'(bus.full), 1);
        run_txn(1'b1, 1'b0, 0, 1'b1);
        run_txn(1'b1, 1'b1, 2, 1'b1);
        check("occ_after_exit", int'(bus.occupancy), 7);
        check("full_clear", int'(bus.full), 0);

`ifdef PARKING_TIMEOUT_EN
        occ_before = int'(bus.occupancy);
        run_txn(1'b1, 1'b0, 1, 1'b0);
        check("occ_after_timeout", int'(bus.occupancy), occ_before);
`endif

        // Reset while in PASS, then exit at empty is refused and entry proceeds.
        bus.entry_req = 1'b1;
        repeat (OPEN_CYCLES + 3) tick();
        check("in_pass_before_reset", int'(bus.entry_grant), 1);
        async_reset();
        check("rst_occupancy", int'(bus.occupancy), 0);
        bus.entry_req = 1'b0;
        run_txn(1'b0, 1'b1, 0, 1'b1);
        run_txn(1'b1, 1'b0, 1, 1'b1);
        check("occ_after_reset_entry", int'(bus.occupancy), 1);

        // Random traffic with drifting entry/exit bias against the model.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 400) % 2 == 0) ? 3 : 1;
            bus.entry_req  = ($urandom_range(0, 3) < bias);
            bus.exit_req   = ($urandom_range(0, 3) >= bias);
            bus.car_passed = ($urandom_range(0, 5) == 0);
            tick();
            if ($urandom_range(0, 599) == 0) async_reset();
        end
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.car_passed = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
